// File: rtl/decode_sequencer_pkg.sv
// Shared types and default sequence lengths for the decode-stage sequencer.
// The *_LEN defaults are also consumed by the memory-stage stack-pointer logic.
package decode_sequencer_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } seq_state_e;

    typedef enum logic [2:0] {
        KIND_NONE = 3'd0,
        KIND_INT  = 3'd1,
        KIND_CALL = 3'd2,
        KIND_RET  = 3'd3,
        KIND_RTI  = 3'd4
    } seq_kind_e;

    // Cycle counts per sequence: INT pushes PC-hi/PC-lo/flags, CALL pushes PC-hi/PC-lo,
    // RET pops PC-lo/PC-hi, RTI pops flags/PC-lo/PC-hi.
    localparam int DEF_INT_LEN  = 3;
    localparam int DEF_CALL_LEN = 2;
    localparam int DEF_RET_LEN  = 2;
    localparam int DEF_RTI_LEN  = 3;
    localparam int DEF_CNT_W    = 2;

    // Sequences that write the stack.
    function automatic logic kind_pushes(input seq_kind_e k);
        return (k == KIND_INT) || (k == KIND_CALL);
    endfunction

    // Sequences that read the stack.
    function automatic logic kind_pops(input seq_kind_e k);
        return (k == KIND_RET) || (k == KIND_RTI);
    endfunction

endpackage

// File: rtl/decode_sequencer_counter.sv
// Loadable down-counter that tracks the remaining cycles of a decode sequence.
// Load wins over decrement; decrement is never requested at zero, so it cannot wrap.
module decode_sequencer_counter #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] cnt;

    // Counter register: load a fresh length, otherwise count down on request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/decode_sequencer.sv
// Decode-stage multi-cycle controller: arbitrates interrupt entry, CALL, RET, RTI and
// load-use stalls, and drives the stall / repeat-iteration / flush / push / pop strobes.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------------
//   ST_IDLE   | no sequence running; arbitrate load-use > interrupt > CALL > RTI > RET
//   ST_ACTIVE | repeat iterations of the latched kind; last one (cnt==0) flushes
module decode_sequencer
    import decode_sequencer_pkg::*;
#(
    parameter int INT_LEN  = DEF_INT_LEN,
    parameter int CALL_LEN = DEF_CALL_LEN,
    parameter int RET_LEN  = DEF_RET_LEN,
    parameter int RTI_LEN  = DEF_RTI_LEN,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic clk,
    input  logic rst_n,
    input  logic valid,
    input  logic call_dec,
    input  logic ret_dec,
    input  logic rti_dec,
    input  logic int_req,
    input  logic load_use,
    output logic stall,
    output logic second_iter,
    output logic flush,
    output logic push_out,
    output logic pop_out,
    output logic int_ack,
    output logic busy
);

    // Every length must be at least 2 and its (LEN-2) preload must fit the counter.
    localparam int CNT_MAX = (1 << CNT_W) - 1;
    if ((INT_LEN < 2) || (CALL_LEN < 2) || (RET_LEN < 2) || (RTI_LEN < 2) ||
        (INT_LEN - 2 > CNT_MAX) || (CALL_LEN - 2 > CNT_MAX) ||
        (RET_LEN - 2 > CNT_MAX) || (RTI_LEN - 2 > CNT_MAX)) begin : g_len_check
        $error("decode_sequencer: sequence length below 2 or too long for CNT_W");
    end

    seq_state_e       state, next_state;
    seq_kind_e        kind, next_kind, trig_kind;
    logic             int_pend, next_int_pend;
    logic             cnt_load, cnt_dec, cnt_zero;
    logic [CNT_W-1:0] cnt_load_val;

    logic stall_c, second_c, flush_c, push_c, pop_c, ack_c, busy_c;

    decode_sequencer_counter #(
        .CNT_W (CNT_W)
    ) u_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    // State, kind and pending-interrupt registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            kind     <= KIND_NONE;
            int_pend <= 1'b0;
        end else begin
            state    <= next_state;
            kind     <= next_kind;
            int_pend <= next_int_pend;
        end
    end

    // Arbitration, next-state and output decode.
    always_comb begin
        next_state   = state;
        next_kind    = kind;
        trig_kind    = KIND_NONE;
        cnt_load     = 1'b0;
        cnt_dec      = 1'b0;
        cnt_load_val = '0;
        stall_c      = 1'b0;
        second_c     = 1'b0;
        flush_c      = 1'b0;
        push_c       = 1'b0;
        pop_c        = 1'b0;
        ack_c        = 1'b0;
        busy_c       = 1'b0;

        case (state)
            ST_IDLE: begin
                if (load_use) begin
                    stall_c = 1'b1;
                end else if (int_req || int_pend) begin
                    trig_kind = KIND_INT;
                end else if (valid && call_dec) begin
                    trig_kind = KIND_CALL;
                end else if (valid && rti_dec) begin
                    trig_kind = KIND_RTI;
                end else if (valid && ret_dec) begin
                    trig_kind = KIND_RET;
                end

                if (trig_kind != KIND_NONE) begin
                    stall_c    = 1'b1;
                    push_c     = kind_pushes(trig_kind);
                    pop_c      = kind_pops(trig_kind);
                    ack_c      = (trig_kind == KIND_INT);
                    next_state = ST_ACTIVE;
                    next_kind  = trig_kind;
                    cnt_load   = 1'b1;
                end

                case (trig_kind)
                    KIND_INT:  cnt_load_val = CNT_W'(INT_LEN - 2);
                    KIND_CALL: cnt_load_val = CNT_W'(CALL_LEN - 2);
                    KIND_RET:  cnt_load_val = CNT_W'(RET_LEN - 2);
                    KIND_RTI:  cnt_load_val = CNT_W'(RTI_LEN - 2);
                    default:   cnt_load_val = '0;
                endcase
            end

            ST_ACTIVE: begin
                second_c = 1'b1;
                busy_c   = 1'b1;
                push_c   = kind_pushes(kind);
                pop_c    = kind_pops(kind);
                if (!cnt_zero) begin
                    stall_c = 1'b1;
                    cnt_dec = 1'b1;
                end else begin
                    flush_c    = 1'b1;
                    next_state = ST_IDLE;
                    next_kind  = KIND_NONE;
                end
            end

            default: begin
                next_state = ST_IDLE;
                next_kind  = KIND_NONE;
            end
        endcase

        // At most one interrupt is held; accepting it clears the flag.
        if (ack_c) begin
            next_int_pend = 1'b0;
        end else if (int_req) begin
            next_int_pend = 1'b1;
        end else begin
            next_int_pend = int_pend;
        end
    end

    // Outputs are combinational from inputs in IDLE, so hold them low during reset.
    assign stall       = rst_n & stall_c;
    assign second_iter = rst_n & second_c;
    assign flush       = rst_n & flush_c;
    assign push_out    = rst_n & push_c;
    assign pop_out     = rst_n & pop_c;
    assign int_ack     = rst_n & ack_c;
    assign busy        = rst_n & busy_c;

endmodule

// File: tb/tb_decode_sequencer.sv
// Table-driven bench for decode_sequencer with a scoreboard queue of expected outputs.
module tb_decode_sequencer;

    logic clk;
    logic rst_n;
    logic valid, call_dec, ret_dec, rti_dec, int_req, load_use;
    logic stall, second_iter, flush, push_out, pop_out, int_ack, busy;

    // Input vector:  {valid, call_dec, ret_dec, rti_dec, int_req, load_use}
    // Output vector: {stall, second_iter, flush, push_out, pop_out, int_ack, busy}
    typedef struct {
        logic [5:0] in;
        logic [6:0] exp;
        string      name;
    } vec_t;

    vec_t       vecs[$];
    logic [6:0] sb_q[$];
    int         checks   = 0;
    int         failures = 0;

    decode_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .valid       (valid),
        .call_dec    (call_dec),
        .ret_dec     (ret_dec),
        .rti_dec     (rti_dec),
        .int_req     (int_req),
        .load_use    (load_use),
        .stall       (stall),
        .second_iter (second_iter),
        .flush       (flush),
        .push_out    (push_out),
        .pop_out     (pop_out),
        .int_ack     (int_ack),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add(input logic [5:0] i, input logic [6:0] e, input string n);
        vec_t v;
        v.in   = i;
        v.exp  = e;
        v.name = n;
        vecs.push_back(v);
    endtask

    // Drive one cycle of inputs after the edge, queue its expectation, compare at negedge.
    task automatic step(input logic rst_v, input logic [5:0] i, input logic [6:0] e,
                        input string n);
        logic [6:0] act;
        logic [6:0] want;
        @(posedge clk);
        #1;
        rst_n = rst_v;
        {valid, call_dec, ret_dec, rti_dec, int_req, load_use} = i;
        sb_q.push_back(e);
        @(negedge clk);
        act = {stall, second_iter, flush, push_out, pop_out, int_ack, busy};
        checks++;
        if (sb_q.size() == 0) begin
            failures++;
            $display("FAIL %s: scoreboard empty, actual=%b", n, act);
        end else begin
            want = sb_q.pop_front();
            if (act !== want) begin
                failures++;
                $display("FAIL %s: actual {stl,sec,fl,push,pop,ack,busy}=%b required=%b",
                         n, act, want);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        {valid, call_dec, ret_dec, rti_dec, int_req, load_use} = '0;

        // Outputs held low in reset even with live requests on the inputs.
        step(1'b0, 6'b110010, 7'b0000000, "reset_forced_low");
        step(1'b0, 6'b000001, 7'b0000000, "reset_forced_low_lu");

        add(6'b000000, 7'b0000000, "idle");
        add(6'b110000, 7'b1001000, "call_t0");
        add(6'b000000, 7'b0111001, "call_t1");
        add(6'b000000, 7'b0000000, "call_done");
        add(6'b100100, 7'b1000100, "rti_t0");
        add(6'b000000, 7'b1100101, "rti_t1");
        add(6'b000000, 7'b0110101, "rti_t2");
        add(6'b000000, 7'b0000000, "rti_done");
        add(6'b101000, 7'b1000100, "ret_t0");
        add(6'b000000, 7'b0110101, "ret_t1");
        add(6'b011000, 7'b0000000, "multi_dec_invalid");
        add(6'b111000, 7'b1001000, "multi_dec_call_t0");
        add(6'b000000, 7'b0111001, "multi_dec_call_t1");
        add(6'b000011, 7'b1000000, "lu_int_stall");
        add(6'b000000, 7'b1001010, "lu_int_ack");
        add(6'b000000, 7'b1101001, "lu_int_t1");
        add(6'b000000, 7'b0111001, "lu_int_t2");
        add(6'b000000, 7'b0000000, "lu_int_pend_clear");
        add(6'b110000, 7'b1001000, "call_int_t0");
        add(6'b000010, 7'b0111001, "call_int_t1_req");
        add(6'b000000, 7'b1001010, "call_int_ack_t2");
        add(6'b000000, 7'b1101001, "call_int_t3");
        add(6'b000000, 7'b0111001, "call_int_t4");
        add(6'b000000, 7'b0000000, "call_int_done");
        add(6'b100100, 7'b1000100, "rti_ign_t0");
        add(6'b110001, 7'b1100101, "rti_ign_t1");
        add(6'b101000, 7'b0110101, "rti_ign_t2");
        add(6'b110001, 7'b1000000, "lu_blocks_call");
        add(6'b110010, 7'b1001010, "int_beats_call");
        add(6'b000000, 7'b1101001, "int_beats_call_t1");
        add(6'b000000, 7'b0111001, "int_beats_call_t2");
        add(6'b000000, 7'b0000000, "int_beats_call_done");
        add(6'b110000, 7'b1001000, "pend_lu_call_t0");
        add(6'b000010, 7'b0111001, "pend_lu_call_t1");
        add(6'b000011, 7'b1000000, "pend_lu_blocked");
        add(6'b000000, 7'b1001010, "pend_lu_ack");
        add(6'b000000, 7'b1101001, "pend_lu_t1");
        add(6'b000000, 7'b0111001, "pend_lu_t2");
        add(6'b000000, 7'b0000000, "pend_lu_done");

        foreach (vecs[k]) begin
            step(1'b1, vecs[k].in, vecs[k].exp, vecs[k].name);
        end

        // Reset mid-INT: request accepted, reset lands on the next cycle.
        step(1'b1, 6'b000010, 7'b1001010, "rst_mid_int_ack");
        step(1'b0, 6'b000010, 7'b0000000, "rst_mid_int_in_reset");
        step(1'b1, 6'b000000, 7'b0000000, "rst_mid_int_release");
        step(1'b1, 6'b000000, 7'b0000000, "rst_mid_int_no_ack");

        // A pending interrupt is dropped by reset.
        step(1'b1, 6'b000011, 7'b1000000, "pend_drop_lu");
        step(1'b0, 6'b000000, 7'b0000000, "pend_drop_reset");
        step(1'b1, 6'b000000, 7'b0000000, "pend_drop_release");
        step(1'b1, 6'b000000, 7'b0000000, "pend_drop_no_ack");

        // Reset during a CALL's final cycle leaves nothing running.
        step(1'b1, 6'b110000, 7'b1001000, "rst_call_t0");
        step(1'b0, 6'b000000, 7'b0000000, "rst_call_in_reset");
        step(1'b1, 6'b000000, 7'b0000000, "rst_call_release");

        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", sb_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
